// File: rtl/ultrasonic_scheduler_pkg.sv
// Shared types and constants for the ultrasonic sensor scheduler.
package ultrasonic_scheduler_pkg;

    localparam int RES_W = 16;
    localparam logic [RES_W-1:0] TIMEOUT_CODE = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
        return (v == TIMEOUT_CODE) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// Sensor pins and SoC read port of the scheduler; slave side is the scheduler itself.
interface ultrasonic_scheduler_if #(parameter int N_SENSORS = 4);
    import ultrasonic_scheduler_pkg::*;

    localparam int SEL_W = $clog2(N_SENSORS);

    logic                 enable;
    logic [N_SENSORS-1:0] echo;
    logic [SEL_W-1:0]     rd_sel;
    logic [N_SENSORS-1:0] trig;
    logic [RES_W-1:0]     rd_data;
    logic [N_SENSORS-1:0] valid;
    logic [N_SENSORS-1:0] timeout;
    logic [SEL_W-1:0]     active;
    logic                 sweep_done;

    modport master (
        output enable, echo, rd_sel,
        input  trig, rd_data, valid, timeout, active, sweep_done
    );

    modport slave (
        input  enable, echo, rd_sel,
        output trig, rd_data, valid, timeout, active, sweep_done
    );

endinterface

// File: rtl/ultrasonic_echo_timer.sv
// Per-line echo front end: 2-FF synchronizer, registered edge pulses and a
// prescaled saturating width counter that runs while the synchronized echo is high.
module ultrasonic_echo_timer
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             echo_in,
    output logic             rise,
    output logic             fall,
    output logic [RES_W-1:0] width
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic          s1, s2, lvl;
    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            presc <= '0;
            width <= '0;
        end else begin
            s1   <= echo_in;
            s2   <= s1;
            lvl  <= s2;
            rise <= s2 & ~lvl;
            fall <= ~s2 & lvl;
            if (clear) begin
                presc <= '0;
                width <= '0;
            end else if (lvl) begin
                if (presc == PW'(PRESCALE - 1)) begin
                    presc <= '0;
                    width <= sat_inc(width);
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin slot scheduler: one sensor fires per slot, its echo is timed and the
// width (or the timeout code) is stored in a per-sensor result register.
module ultrasonic_scheduler
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int N_SENSORS   = 4,
    parameter int TRIG_CYCLES = 1200,
    parameter int SLOT_CYCLES = 25_000_000,
    parameter int PRESCALE    = 50
) (
    input logic                 clk,
    input logic                 rst_n,
    ultrasonic_scheduler_if.slave bus
);

    localparam int SEL_W = $clog2(N_SENSORS);

    state_t                              state, state_nx;
    logic [31:0]                         slot_tmr;
    logic [SEL_W-1:0]                    active, active_inc, active_nx;
    logic                                got_res;
    logic [N_SENSORS-1:0][RES_W-1:0]     result;
    logic [N_SENSORS-1:0]                valid, tout, trig;
    logic                                sweep_done;
    logic                                slot_end, clear, latch;
    logic [N_SENSORS-1:0]                rise, fall;
    logic [N_SENSORS-1:0][RES_W-1:0]     width;
    logic [RES_W-1:0]                    rd_mux;

    // One front end per echo line so every line is synchronized independently;
    // only the active lane's outputs are ever consumed.
    for (genvar i = 0; i < N_SENSORS; i++) begin : g_lane
        ultrasonic_echo_timer #(.PRESCALE(PRESCALE)) u_tmr (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear && (active == SEL_W'(i))),
            .echo_in (bus.echo[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .width   (width[i])
        );
    end

    assign slot_end   = (state != IDLE) && (slot_tmr == 32'(SLOT_CYCLES - 1));
    assign active_inc = (active == SEL_W'(N_SENSORS - 1)) ? '0 : active + 1'b1;
    assign active_nx  = slot_end ? active_inc : active;

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE:      if (bus.enable) state_nx = TRIG;
            TRIG:      if (slot_tmr == 32'(TRIG_CYCLES - 1)) state_nx = WAIT_ECHO;
            WAIT_ECHO: if (rise[active]) begin
                           state_nx = MEASURE;
                           clear    = 1'b1;
                       end
            MEASURE:   if (fall[active]) begin
                           state_nx = SETTLE;
                           latch    = 1'b1;
                       end
            SETTLE:    state_nx = SETTLE;
            default:   state_nx = IDLE;
        endcase
        // Slot end overrides any edge seen in the same cycle.
        if (slot_end) begin
            state_nx = bus.enable ? TRIG : IDLE;
            clear    = 1'b0;
            latch    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_tmr   <= '0;
            active     <= '0;
            got_res    <= 1'b0;
            result     <= '0;
            valid      <= '0;
            tout       <= '0;
            trig       <= '0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nx;
            active     <= active_nx;
            sweep_done <= 1'b0;
            slot_tmr   <= (state == IDLE || slot_end) ? 32'd0 : slot_tmr + 32'd1;
            if (latch) begin
                result[active] <= width[active];
                tout[active]   <= 1'b0;
                got_res        <= 1'b1;
            end
            if (slot_end) begin
                if (!got_res) begin
                    result[active] <= TIMEOUT_CODE;
                    tout[active]   <= 1'b1;
                end
                valid[active] <= 1'b1;
                got_res       <= 1'b0;
                sweep_done    <= (active == SEL_W'(N_SENSORS - 1));
            end
            // Registered from next state so the pin rises in the first TRIG cycle.
            trig <= '0;
            if (state_nx == TRIG) trig[active_nx] <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SENSORS; i++)
            if (bus.rd_sel == SEL_W'(i)) rd_mux = result[i];
    end

    assign bus.trig       = trig;
    assign bus.rd_data    = rd_mux;
    assign bus.valid      = valid;
    assign bus.timeout    = tout;
    assign bus.active     = active;
    assign bus.sweep_done = sweep_done;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with short slots (TRIG=4, SLOT=200, PRESCALE=2).
module tb_ultrasonic_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pe = 0;
    int   base = 0;
    int   total = 0;
    int   bad = 0;
    logic multi_trig = 1'b0;
    logic [15:0] rv;

    ultrasonic_scheduler_if #(.N_SENSORS(4)) bus ();

    ultrasonic_scheduler #(
        .N_SENSORS(4), .TRIG_CYCLES(4), .SLOT_CYCLES(200), .PRESCALE(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;
    always @(negedge clk) if (!$onehot0(bus.trig)) multi_trig = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        logic ok;
        ok = (obs >= 32'(lo)) && (obs <= 32'(hi));
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Sample point of slot-relative cycle k (negedge after posedge base+k).
    task automatic at(input int k);
        while (pe < base + k) @(negedge clk);
    endtask

    task automatic rd(input int sel, output logic [15:0] v);
        bus.rd_sel = 2'(sel);
        #1;
        v = bus.rd_data;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.echo   = '0;
        bus.rd_sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_trig", bus.trig, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_sweep_done", bus.sweep_done, 0);
        rd(0, rv); chk("rst_res0", rv, 0);
        rd(3, rv); chk("rst_res3", rv, 0);

        // Sweep 1: normal echo, missing echo, stale-high echo, overrun echo.
        bus.enable = 1'b1;
        base = pe + 1;
        at(0);   chk("trig_first", bus.trig, 4'b0001);
        at(3);   chk("trig_last", bus.trig, 4'b0001);
        at(4);   chk("trig_off", bus.trig, 4'b0000);
        at(14);  bus.echo[0] = 1'b1;
        at(54);  bus.echo[0] = 1'b0;
        at(60);  rd(0, rv); chk_rng("single_res0", rv, 19, 21);
        chk("single_timeout0", bus.timeout[0], 0);
        at(199); chk("active_199", bus.active, 0);
        at(200); chk("active_200", bus.active, 1);
        chk("valid_200", bus.valid, 4'b0001);
        chk("timeout_200", bus.timeout, 4'b0000);
        at(250); bus.echo[2] = 1'b1;
        at(270); bus.echo[2] = 1'b0;
        at(399); chk("active_399", bus.active, 1);
        at(400); chk("active_400", bus.active, 2);
        rd(1, rv); chk("missing_res1", rv, 16'hFFFF);
        chk("timeout_400", bus.timeout, 4'b0010);
        chk("valid_400", bus.valid, 4'b0011);
        chk("sweep_done_400", bus.sweep_done, 0);
        bus.echo[2] = 1'b1;
        at(420); bus.echo[2] = 1'b0;
        at(430); bus.echo[2] = 1'b1;
        at(460); bus.echo[2] = 1'b0;
        at(470); rd(2, rv); chk_rng("fresh_edge_res2", rv, 14, 16);
        at(610); bus.echo[3] = 1'b1;
        at(799); chk("sweep_done_799", bus.sweep_done, 0);
        at(800); chk("sweep_done_800", bus.sweep_done, 1);
        chk("active_800", bus.active, 0);
        rd(3, rv); chk("overrun_res3", rv, 16'hFFFF);
        chk("timeout_800", bus.timeout, 4'b1010);
        chk("valid_800", bus.valid, 4'b1111);
        at(801); chk("sweep_done_801", bus.sweep_done, 0);

        // Sweep 2: echoes of 10/20/30/40 cycles on sensors 0..3.
        at(810); bus.echo[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            at(800 + 200 * s + 10);             bus.echo[s] = 1'b1;
            at(800 + 200 * s + 10 + 10 * (s + 1)); bus.echo[s] = 1'b0;
        end
        at(1600); chk("sweep_done_1600", bus.sweep_done, 1);
        chk("timeout_1600", bus.timeout, 4'b0000);
        rd(0, rv); chk_rng("sweep_res0", rv, 4, 6);
        rd(1, rv); chk_rng("sweep_res1", rv, 9, 11);
        rd(2, rv); chk_rng("sweep_res2", rv, 14, 16);
        rd(3, rv); chk_rng("sweep_res3", rv, 19, 21);

        // Sweep 3: enable dropped mid-slot 0.
        at(1610); bus.echo[0] = 1'b1;
        at(1630); bus.echo[0] = 1'b0;
        at(1650); bus.enable = 1'b0;
        at(1700); rd(0, rv); chk_rng("drop_res0", rv, 9, 11);
        at(1800); chk("drop_active", bus.active, 1);
        chk("drop_trig_1800", bus.trig, 0);
        chk("drop_valid", bus.valid, 4'b1111);
        at(1900); chk("idle_trig_1900", bus.trig, 0);
        chk("idle_active_1900", bus.active, 1);

        // Restart on sensor 1, then reset during MEASURE.
        bus.enable = 1'b1;
        base = pe + 1;
        at(0);  chk("restart_trig", bus.trig, 4'b0010);
        at(10); bus.echo[1] = 1'b1;
        at(20); rst_n = 1'b0;
        #1;
        chk("rstmid_trig", bus.trig, 0);
        chk("rstmid_valid", bus.valid, 0);
        chk("rstmid_active", bus.active, 0);
        chk("rstmid_timeout", bus.timeout, 0);
        for (int s = 0; s < 4; s++) begin
            rd(s, rv); chk($sformatf("rstmid_res%0d", s), rv, 0);
        end
        bus.echo   = '0;
        bus.enable = 1'b0;
        at(23); rst_n = 1'b1;
        at(30); chk("post_rst_trig", bus.trig, 0);
        chk("trig_onehot", multi_trig, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ultrasonic_scheduler.md
# ultrasonic_scheduler

Time-multiplexes one measurement sequence across `N_SENSORS` ultrasonic rangefinders on the vacuum cleaner, so that only one transducer fires at a time and neighbouring sensors do not cross-talk. Per sensor, it issues the trigger pulse, times the echo, and stores a 16-bit result per sensor for the SoC to read. It sits between the sensor pins and the SoC peripheral bus. It replaces per-sensor free-running controllers.

## Interface
- `N_SENSORS`, 4: number of sensors, 2..8.
- `TRIG_CYCLES`, 1200: trigger high time in clk cycles.
- `SLOT_CYCLES`, 25_000_000: length of one sensor slot in clk cycles (trigger + echo + settle).
- `PRESCALE`, 50: clk cycles per result LSB (1 µs at 50 MHz).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: 1 = run sweeps continuously; 0 = finish current slot, then idle.
- `echo` input N_SENSORS: raw echo lines, asynchronous.
- `rd_sel` input $clog2(N_SENSORS): result index to read.
- `trig` output N_SENSORS: trigger lines, at most one bit high (one-hot or zero).
- `rd_data` output 16: result of sensor `rd_sel` (combinational mux of the result registers).
- `valid` output N_SENSORS: bit i set once sensor i holds a result from the current run; cleared on reset only.
- `timeout` output N_SENSORS: bit i = last measurement of sensor i saw no complete echo.
- `active` output $clog2(N_SENSORS): index of the sensor owning the current slot.
- `sweep_done` output 1: one-cycle pulse at the end of the last sensor's slot.

## Operation
- Each `echo` bit passes through a 2-FF synchronizer before use. Echo edges are detected on the synchronized signal.
- FSM states:
  - **IDLE**:
    - `trig`=0; `active` holds.
    - Go to TRIG when `enable`=1; the slot timer resets to 0.
  - **TRIG**:
    - `trig[active]`=1 for exactly `TRIG_CYCLES` cycles.
    - Then go to WAIT_ECHO.
  - **WAIT_ECHO**:
    - On a synchronized rising edge of `echo[active]`, clear the width counter and go to MEASURE.
  - **MEASURE**:
    - A prescaler counts clk cycles; every `PRESCALE` cycles the width counter increments, saturating at 16'hFFFF.
    - On a synchronized falling edge, latch the width into result[active] and clear `timeout[active]`.
    - Then go to SETTLE.
  - **SETTLE**:
    - Wait until the slot timer reaches `SLOT_CYCLES`-1.
  - **Slot end** (from any of TRIG, WAIT_ECHO, MEASURE or SETTLE when the slot timer reaches `SLOT_CYCLES`-1):
    - If no result was latched this slot: result[active]=16'hFFFF and `timeout[active]`=1.
    - Set `valid[active]`.
    - Advance `active`, wrapping from N_SENSORS-1 to 0.
    - If the wrap occurred, pulse `sweep_done`.
    - Next state is TRIG if `enable`=1, else IDLE.
- The slot timer is 32 bits and runs from slot start. The slot-end check has priority over every other transition in the same cycle.
- Echo activity on non-active sensors is ignored.
- An echo already high when WAIT_ECHO is entered is not a rising edge. The sensor waits for a fresh edge.
- Deasserting `enable` mid-slot does not abort the slot; it only prevents the next slot from starting.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `trig`: 0.
  - `active`: 0.
  - `valid` and `timeout`: 0.
  - All results: 0.
  - `sweep_done`: 0.
- `trig[active]` rises in the first TRIG cycle, one cycle after `enable` is sampled high in IDLE.
- Echo-edge detection latency: 3 cycles (2 synchronizer stages plus the edge register).
- A result is visible on `rd_data` 1 cycle after the falling edge is detected.
- Width = floor(high cycles / `PRESCALE`) ±1 LSB, due to prescaler phase.
- `sweep_done` is registered. It is coincident with the `active` wrap to 0.
- Asserting `rst_n` low mid-slot drops `trig` immediately and returns all state to its reset values.
- Sweep period = N_SENSORS × `SLOT_CYCLES`, exactly.

## Structure
- A shared header holds:
  - the FSM state localparams (IDLE, TRIG, WAIT_ECHO, MEASURE, SETTLE), 3-bit;
  - the 16'hFFFF timeout code;
  - the result width.
- One sub-module, `ultrasonic_echo_timer`: synchronizer, edge detect, prescaler and saturating width counter for the selected echo line.
  - Inputs: `clk`, `rst_n`, `clear`, `echo_in`.
  - Outputs: `rise`, `fall`, `width[15:0]`.
- The top level contains the FSM, the slot timer, the result register file and the read mux.

## Test plan
All scenarios use `TRIG_CYCLES`=4, `SLOT_CYCLES`=200, `PRESCALE`=2, `N_SENSORS`=4.
- **Single sensor:** after reset, set `enable`=1 and drive `echo[0]` high for 40 cycles starting 10 cycles after trig falls → `trig[0]` high exactly 4 cycles; result[0]=20 ±1; `valid[0]`=1; `timeout[0]`=0.
- **Missing echo:** hold `echo[1]` low for a whole slot → result[1]=16'hFFFF; `timeout[1]`=1; `active` advances to 2 at cycle 400.
- **Full sweep:** give all four sensors echoes of 10/20/30/40 cycles → results 5/10/15/20; `sweep_done` is a single pulse at cycle 800; `trig` never has more than one bit high.
- **Saturation and late fall:** echo high from shortly after trig until past slot end → the result is the timeout code, and the width counter never wraps.
- **Enable drop:** deassert `enable` at cycle 50 of slot 0 → the slot completes and its result is stored; FSM goes to IDLE at cycle 200; `trig` stays 0 thereafter.
- **Reset mid-measure:** pulse `rst_n` low during MEASURE → `trig`, `valid` and `active` are 0 within the same cycle, and all results read 0.
